// File: rtl/nn_core_param_if.sv
// nn_core_param_if: bundle of the inference core's control handshake and its
// four read-only memory ports (bitmap, hidden weights, output weights, LUT).
//
//   start      request an inference (driven by master)
//   busy/done  core status; done is a one-cycle result strobe
//   digit      arg-max output index, max_score its unsigned LUT score
//   x_addr     -> x_bit    bitmap read, 1-cycle latency
//   wh_addr    -> wh_q     hidden weight read (hid*N_IN + in), 1-cycle latency
//   wo_addr    -> wo_q     output weight read (out*N_HID + hid), 1-cycle latency
//   lut_addr   -> lut_q    activation LUT read, 1-cycle latency
//
// master: host/memory side. slave: the core.
interface nn_core_param_if #(
  parameter int unsigned N_IN  = 784,
  parameter int unsigned N_HID = 32,
  parameter int unsigned N_OUT = 10
) ();

  logic                             start;
  logic                             busy;
  logic                             done;
  logic [$clog2(N_OUT)-1:0]         digit;
  logic [7:0]                       max_score;
  logic [$clog2(N_IN)-1:0]          x_addr;
  logic                             x_bit;
  logic [$clog2(N_HID*N_IN)-1:0]    wh_addr;
  logic [7:0]                       wh_q;
  logic [$clog2(N_OUT*N_HID)-1:0]   wo_addr;
  logic [7:0]                       wo_q;
  logic [10:0]                      lut_addr;
  logic [7:0]                       lut_q;

  modport master (
    output start, x_bit, wh_q, wo_q, lut_q,
    input  busy, done, digit, max_score, x_addr, wh_addr, wo_addr, lut_addr
  );

  modport slave (
    input  start, x_bit, wh_q, wo_q, lut_q,
    output busy, done, digit, max_score, x_addr, wh_addr, wo_addr, lut_addr
  );

endinterface

// File: rtl/nn_core_param.sv
// nn_core_param: two-layer binary-input inference core. Streams the bitmap
// through N_HID hidden MAC neurons and N_OUT output MAC neurons, applies the
// shared activation LUT after each neuron, and reports the arg-max output.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; aborts any inference in flight
//   bus   nn_core_param_if slave: start/busy/done/digit/max_score plus the
//         bitmap, hidden-weight, output-weight and LUT read ports
//
// Every memory read returns data one cycle after its address, so each MAC
// phase is followed by a drain cycle that accumulates the last product.
module nn_core_param #(
  parameter int unsigned N_IN  = 784,
  parameter int unsigned N_HID = 32,
  parameter int unsigned N_OUT = 10,
  parameter int unsigned ACC_W = 26
) (
  input logic            clk,
  input logic            rst,
  nn_core_param_if.slave bus
);

  localparam int unsigned XW  = $clog2(N_IN);
  localparam int unsigned HW  = $clog2(N_HID);
  localparam int unsigned OW  = $clog2(N_OUT);
  localparam int unsigned WHW = $clog2(N_HID * N_IN);
  localparam int unsigned WOW = $clog2(N_OUT * N_HID);
  localparam int unsigned SW  = ACC_W - 7;

  typedef enum logic [3:0] {
    StIdle,
    StHidMac,
    StHidDrain,
    StHidLut,
    StHidWr,
    StOutMac,
    StOutDrain,
    StOutLut,
    StOutCmp,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [XW-1:0]           in_q, in_d;
  logic [HW-1:0]           hid_q, hid_d;
  logic [OW-1:0]           out_q, out_d;
  logic [WHW-1:0]          wh_ptr_q, wh_ptr_d;
  logic [WOW-1:0]          wo_ptr_q, wo_ptr_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    mac_vld_q, mac_vld_d;
  logic [7:0]              max_q, max_d;
  logic [OW-1:0]           arg_q, arg_d;
  logic [OW-1:0]           digit_q, digit_d;
  logic [7:0]              score_q, score_d;

  // Hidden activations; not reset, always written before being read.
  logic [7:0]              hidden_ram [N_HID];
  logic [7:0]              hid_rd_q;

  // Products: the hidden layer multiplies by ext(x_bit) = 127 or 0.
  logic signed [15:0]      wh_ext, wo_ext, hv_ext;
  logic signed [15:0]      hid_prod, out_prod, prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic                    phase_hid;

  assign wh_ext    = 16'($signed(bus.wh_q));
  assign wo_ext    = 16'($signed(bus.wo_q));
  assign hv_ext    = 16'($signed(hid_rd_q));
  assign hid_prod  = bus.x_bit ? (wh_ext * 16'sd127) : 16'sd0;
  assign out_prod  = hv_ext * wo_ext;
  assign phase_hid = (state_q == StHidMac) || (state_q == StHidDrain);
  assign prod      = phase_hid ? hid_prod : out_prod;
  assign prod_ext  = ACC_W'(prod);

  // rect(): drop 7 fraction bits, saturate to [-1024, 1023], offset by 1024.
  logic signed [SW-1:0]    s_raw, s_sat;
  logic [10:0]             rect_addr;

  assign s_raw = acc_q[ACC_W-1:7];

  always_comb begin
    if (s_raw > SW'(1023)) begin
      s_sat = SW'(1023);
    end else if (s_raw < SW'(-1024)) begin
      s_sat = SW'(-1024);
    end else begin
      s_sat = s_raw;
    end
  end

  assign rect_addr = 11'(s_sat + SW'(1024));

  always_comb begin
    state_d   = state_q;
    in_d      = in_q;
    hid_d     = hid_q;
    out_d     = out_q;
    wh_ptr_d  = wh_ptr_q;
    wo_ptr_d  = wo_ptr_q;
    acc_d     = acc_q;
    max_d     = max_q;
    arg_d     = arg_q;
    digit_d   = digit_q;
    score_d   = score_q;
    mac_vld_d = (state_q == StHidMac) || (state_q == StOutMac);

    // Data for an address issued last cycle arrives now.
    if (mac_vld_q) begin
      acc_d = acc_q + prod_ext;
    end

    case (state_q)
      StIdle: begin
        in_d     = '0;
        hid_d    = '0;
        out_d    = '0;
        wh_ptr_d = '0;
        wo_ptr_d = '0;
        acc_d    = '0;
        if (bus.start) begin
          state_d = StHidMac;
        end
      end
      StHidMac: begin
        // Weight pointer runs continuously across neurons: hid*N_IN + in.
        wh_ptr_d = wh_ptr_q + WHW'(1);
        if (in_q == XW'(N_IN - 1)) begin
          in_d    = '0;
          state_d = StHidDrain;
        end else begin
          in_d = in_q + XW'(1);
        end
      end
      StHidDrain: state_d = StHidLut;
      StHidLut:   state_d = StHidWr;
      StHidWr: begin
        acc_d = '0;
        if (hid_q == HW'(N_HID - 1)) begin
          hid_d   = '0;
          state_d = StOutMac;
        end else begin
          hid_d   = hid_q + HW'(1);
          state_d = StHidMac;
        end
      end
      StOutMac: begin
        wo_ptr_d = wo_ptr_q + WOW'(1);
        if (hid_q == HW'(N_HID - 1)) begin
          hid_d   = '0;
          state_d = StOutDrain;
        end else begin
          hid_d = hid_q + HW'(1);
        end
      end
      StOutDrain: state_d = StOutLut;
      StOutLut:   state_d = StOutCmp;
      StOutCmp: begin
        acc_d = '0;
        // Strictly greater keeps the lowest index on ties.
        if ((out_q == '0) || (bus.lut_q > max_q)) begin
          max_d = bus.lut_q;
          arg_d = out_q;
        end
        if (out_q == OW'(N_OUT - 1)) begin
          // Publish on entry to DONE so results are valid with the done pulse.
          digit_d = arg_d;
          score_d = max_d;
          state_d = StDone;
        end else begin
          out_d   = out_q + OW'(1);
          state_d = StOutMac;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      in_q      <= '0;
      hid_q     <= '0;
      out_q     <= '0;
      wh_ptr_q  <= '0;
      wo_ptr_q  <= '0;
      acc_q     <= '0;
      mac_vld_q <= 1'b0;
      max_q     <= '0;
      arg_q     <= '0;
      digit_q   <= '0;
      score_q   <= '0;
    end else begin
      state_q   <= state_d;
      in_q      <= in_d;
      hid_q     <= hid_d;
      out_q     <= out_d;
      wh_ptr_q  <= wh_ptr_d;
      wo_ptr_q  <= wo_ptr_d;
      acc_q     <= acc_d;
      mac_vld_q <= mac_vld_d;
      max_q     <= max_d;
      arg_q     <= arg_d;
      digit_q   <= digit_d;
      score_q   <= score_d;
    end
  end

  // Hidden RAM: written in HID_WR; read each cycle so the value lines up
  // with the output weight returned for the same hid index.
  always_ff @(posedge clk) begin
    if (state_q == StHidWr) begin
      hidden_ram[hid_q] <= bus.lut_q;
    end
    hid_rd_q <= hidden_ram[hid_q];
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.digit     = digit_q;
  assign bus.max_score = score_q;
  assign bus.x_addr    = (state_q == StHidMac) ? in_q : '0;
  assign bus.wh_addr   = (state_q == StHidMac) ? wh_ptr_q : '0;
  assign bus.wo_addr   = (state_q == StOutMac) ? wo_ptr_q : '0;
  assign bus.lut_addr  = ((state_q == StHidLut) || (state_q == StOutLut)) ? rect_addr : '0;

endmodule

// File: tb/tb_nn_core_param.sv
// tb_nn_core_param: directed bench for nn_core_param. A small instance
// (N_IN=4, N_HID=2, N_OUT=3) checks arg-max, tie and unsigned-compare cases,
// ignored/held start and mid-run reset; a default instance checks full
// latency and LUT-address saturation in both directions.
//
// Small instance ROMs: bitmap = {1,1,1,0}; LUT returns lut_addr[7:0], so a
// neuron's LUT value is the low byte of floor(acc/128).
//   scen 0: hidden sums 128 and 0 -> hidden {127, 0};
//           output weights (hid0) 11, -56, -56 -> scores {10, 200, 200}
//   scen 1: both hidden sums 128 -> hidden {127, 127};
//           output weight sums 130, 128, -1 -> scores {0x80, 0x7F, 0xFF}
module tb_nn_core_param;

  localparam int unsigned SI = 4;
  localparam int unsigned SH = 2;
  localparam int unsigned SO = 3;

  logic clk = 1'b0;
  logic rst;
  logic start_s;
  logic start_b;
  int   n_checks = 0;
  int   n_errors = 0;
  int   scen;
  logic big_x;
  logic big_sat;

  always #5 clk = ~clk;

  nn_core_param_if #(.N_IN(SI), .N_HID(SH), .N_OUT(SO)) sb ();
  nn_core_param_if bb ();

  assign sb.start = start_s;
  assign bb.start = start_b;

  nn_core_param #(.N_IN(SI), .N_HID(SH), .N_OUT(SO), .ACC_W(26)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (sb)
  );

  nn_core_param u_big (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  function automatic logic [7:0] small_wh(input int a);
    int hid;
    int idx;
    hid = a / SI;
    idx = a % SI;
    if (hid == 0 || scen == 1) begin
      case (idx)
        0:       return 8'd40;
        1:       return 8'd44;
        2:       return 8'd44;
        default: return 8'd99;
      endcase
    end
    case (idx)
      0:       return 8'd5;
      1:       return 8'hFB;
      2:       return 8'd0;
      default: return 8'd100;
    endcase
  endfunction

  function automatic logic [7:0] small_wo(input int a);
    if (scen == 0) begin
      case (a)
        0:       return 8'd11;
        2, 4:    return 8'hC8;
        default: return 8'd77;
      endcase
    end
    case (a)
      0, 1:    return 8'd65;
      2, 3:    return 8'd64;
      4:       return 8'hFF;
      default: return 8'd0;
    endcase
  endfunction

  // Synchronous ROM models, 1-cycle latency.
  always @(posedge clk) begin
    sb.x_bit <= (sb.x_addr != 2'd3);
    sb.wh_q  <= small_wh(int'(sb.wh_addr));
    sb.wo_q  <= small_wo(int'(sb.wo_addr));
    sb.lut_q <= sb.lut_addr[7:0];
    bb.x_bit <= big_x;
    bb.wh_q  <= (!big_sat || ((int'(bb.wh_addr) / 784) % 2 == 0)) ? 8'd127 : 8'h80;
    bb.wo_q  <= 8'd0;
    bb.lut_q <= bb.lut_addr[10:3];
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_start(input bit big, input logic v);
    if (big) start_b = v;
    else     start_s = v;
  endtask

  // One start pulse; lat = n where done is seen after edge E0+n (-1 on timeout).
  task automatic run_inf(input bit big, input int limit, input int pulse_n, input int pa,
                         input int pb, output int lat, output int busy_low,
                         output int lut_a, output int lut_b);
    lat      = -1;
    busy_low = 0;
    lut_a    = -1;
    lut_b    = -1;
    @(negedge clk);
    set_start(big, 1'b1);
    @(negedge clk);
    set_start(big, 1'b0);
    for (int n = 1; n <= limit && lat < 0; n++) begin
      set_start(big, n == pulse_n);
      @(negedge clk);
      if (!(big ? bb.busy : sb.busy)) busy_low++;
      if (n == pa) lut_a = int'(big ? bb.lut_addr : sb.lut_addr);
      if (n == pb) lut_b = int'(big ? bb.lut_addr : sb.lut_addr);
      if (big ? bb.done : sb.done) lat = n;
    end
    set_start(big, 1'b0);
  endtask

  initial begin
    int lat;
    int bl;
    int la;
    int lb;
    int cnt;
    int first;
    int gap;
    rst     = 1'b1;
    start_s = 1'b0;
    start_b = 1'b0;
    scen    = 0;
    big_x   = 1'b0;
    big_sat = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", sb.busy, 0);
    check_eq("rst_done", sb.done, 0);
    check_eq("rst_digit", sb.digit, 0);
    check_eq("rst_score", sb.max_score, 0);
    check_eq("rst_addrs", sb.x_addr + sb.wh_addr + sb.wo_addr + sb.lut_addr, 0);
    check_eq("rst_big_busy", bb.busy, 0);
    rst = 1'b0;

    // Tie case.
    run_inf(0, 60, 0, 0, 0, lat, bl, la, lb);
    check_eq("a_latency", lat, 29);
    check_eq("a_digit", sb.digit, 1);
    check_eq("a_score", sb.max_score, 200);
    check_eq("a_busy_low", bl, 0);
    @(negedge clk);
    check_eq("a_done_pulse", sb.done, 0);
    check_eq("a_idle", sb.busy, 0);
    check_eq("a_digit_held", sb.digit, 1);

    // Start pulsed mid-run is ignored.
    run_inf(0, 60, 10, 0, 0, lat, bl, la, lb);
    check_eq("mid_latency", lat, 29);
    check_eq("mid_digit", sb.digit, 1);
    check_eq("mid_score", sb.max_score, 200);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (sb.done) cnt++;
    end
    check_eq("mid_no_extra_done", cnt, 0);

    // Unsigned compare.
    scen = 1;
    run_inf(0, 60, 0, 0, 0, lat, bl, la, lb);
    check_eq("b_latency", lat, 29);
    check_eq("b_digit", sb.digit, 2);
    check_eq("b_score", sb.max_score, 255);

    // Start held high: back-to-back runs, done every 31 cycles.
    scen  = 0;
    first = -1;
    gap   = -1;
    @(negedge clk);
    start_s = 1'b1;
    for (int n = 1; n <= 40 && first < 0; n++) begin
      @(negedge clk);
      if (sb.done) first = n;
    end
    for (int n = 1; n <= 40 && gap < 0; n++) begin
      @(negedge clk);
      if (sb.done) gap = n;
    end
    start_s = 1'b0;
    check_eq("held_first", first, 30);
    check_eq("held_gap", gap, 31);
    check_eq("held_digit", sb.digit, 1);
    repeat (3) @(negedge clk);
    check_eq("held_stops", sb.busy, 0);

    // Reset mid-inference.
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("pre_rst_busy", sb.busy, 1);
    rst = 1'b1;
    #1;
    check_eq("arst_busy", sb.busy, 0);
    check_eq("arst_digit", sb.digit, 0);
    check_eq("arst_score", sb.max_score, 0);
    check_eq("arst_addrs", sb.x_addr + sb.wh_addr + sb.wo_addr + sb.lut_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (sb.done) cnt++;
    end
    check_eq("arst_no_done", cnt, 0);
    run_inf(0, 60, 0, 0, 0, lat, bl, la, lb);
    check_eq("post_rst_latency", lat, 29);
    check_eq("post_rst_digit", sb.digit, 1);
    check_eq("post_rst_score", sb.max_score, 200);

    // Default configuration, blank bitmap; start pulsed at E0+100.
    run_inf(1, 25600, 100, 785, 0, lat, bl, la, lb);
    check_eq("dflt_latency", lat, 25534);
    check_eq("dflt_busy_low", bl, 0);
    check_eq("dflt_hid_lut", la, 1024);
    check_eq("dflt_digit", bb.digit, 0);
    check_eq("dflt_score", bb.max_score, 128);
    @(negedge clk);
    check_eq("dflt_done_pulse", bb.done, 0);

    // Default configuration, full bitmap, weights +127 / -128 by hidden parity.
    big_x   = 1'b1;
    big_sat = 1'b1;
    run_inf(1, 25600, 0, 785, 1572, lat, bl, la, lb);
    check_eq("sat_hi_lut", la, 2047);
    check_eq("sat_lo_lut", lb, 0);
    check_eq("sat_latency", lat, 25534);
    check_eq("sat_digit", bb.digit, 0);
    check_eq("sat_score", bb.max_score, 128);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
